window_compare: RTL and testbench
=================================

# window_compare

Streaming magnitude comparator with window tally. Accepts a stream of operand pairs (a, b) over a valid/ready handshake and registers a one-hot per-pair verdict: 3'b001 for a>b, 3'b010 for a==b, 3'b100 for a<b. It counts verdicts over a window of WINDOW pairs and presents the three tallies as a held summary under a second handshake. It sits between a sample source and downstream decision logic that needs both per-sample and per-window comparison results.

## Interface
Parameters:
- WIDTH, 4, operand width in bits (≥1)
- WINDOW, 8, pairs per summary window (≥1)
- CW, $clog2(WINDOW+1), tally width (derived; do not override)

Ports:
- clk  in  1  rising-edge clock; the block's only clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  pair offered
- in_ready  out  1  pair can be accepted
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- sgn  in  1  1 = two's-complement compare, 0 = unsigned; sampled with the pair
- flush  in  1  close the current window early
- y_valid  out  1  one-cycle pulse: y holds a new verdict
- y  out  3  one-hot verdict of the last accepted pair
- sum_valid  out  1  summary presented
- sum_ready  in  1  summary consumed
- cnt_gt, cnt_eq, cnt_lt  out  CW each  window tallies

## Operation
- State machine with two states:
  - ACCUM: in_ready=1.
  - REPORT: in_ready=0, sum_valid=1.
- Accept: a pair is accepted on any edge where in_valid && in_ready. On that edge:
  - y is loaded with the verdict.
  - y_valid is set for exactly one cycle.
  - The matching tally increments.
  - pair_cnt increments.
- y holds its value between acceptances; y_valid is low otherwise.
- ACCUM→REPORT when either:
  - a pair is accepted while pair_cnt==WINDOW-1, or
  - flush=1 and (pair_cnt>0 or a pair is accepted this cycle). A pair accepted in the flush cycle is included in the tallies.
- flush ignored cases:
  - flush with pair_cnt==0 and no acceptance.
  - flush in REPORT.
- REPORT behaviour:
  - cnt_* and sum_valid are held stable.
  - in_valid is ignored.
- REPORT→ACCUM on sum_ready=1. On that edge cnt_* and pair_cnt clear to 0.
- Invariant: cnt_gt+cnt_eq+cnt_lt equals pairs accepted in the window. No tally can overflow, because CW covers WINDOW.
- Reset values (async rst): state=ACCUM, y=3'b000, y_valid=0, sum_valid=0, cnt_*=0, pair_cnt=0. Reset mid-window discards the partial window without a summary.

## Timing
- Verdict latency: 1 cycle. y and y_valid are visible the cycle after acceptance.
- Summary latency: sum_valid rises the cycle after the closing acceptance (or the flush cycle). The closing pair's y_valid pulse coincides with it.
- in_ready is low from that cycle until the cycle after sum_ready is sampled high. Minimum gap is one dead cycle between windows.
- Full throughput inside a window: one pair per cycle.
- in_ready depends only on state, never combinationally on in_valid.

## Configuration
- COMPARE_SIGNED_EN defined:
  - sgn selects signed/unsigned comparison per pair.
  - Signed comparison treats a and b as two's complement of WIDTH bits.
- Not defined:
  - sgn is ignored.
  - All comparisons are unsigned.
  - No signed logic is synthesized.
  - The port remains present.

## Structure
- Shared package window_compare_pkg:
  - Verdict constants CMP_GT=3'b001, CMP_EQ=3'b010, CMP_LT=3'b100.
  - State enum {ST_ACCUM, ST_REPORT}.
- One sub-module, cmp_core: purely combinational WIDTH-bit compare (a, b, sgn → one-hot verdict). Used for the per-pair decision.
- window_compare holds the handshake, state machine, verdict register and tallies.

## Test plan
Bench configuration for all scenarios: WIDTH=4, WINDOW=4.
- Reset asserted mid-run → y=000, y_valid=0, sum_valid=0, cnt_*=0, in_ready=1 immediately (async).
- Pairs (5,3),(3,3),(2,9),(15,0) back-to-back, sgn=0:
  - y = 001, 010, 100, 001 on consecutive cycles.
  - sum_valid next cycle with gt=2, eq=1, lt=1.
  - in_ready=0 until sum_ready.
- Signed compare, a=4'b1111, b=4'b0001:
  - With COMPARE_SIGNED_EN: sgn=1 → y=100; sgn=0 → y=001.
  - Without the macro: y=001 for both sgn values.
- Two pairs (1,2),(7,7), then flush alone → summary gt=0, eq=1, lt=1. Flush asserted together with the 2nd pair's acceptance → same summary. Flush with empty window → no summary.
- Backpressure: summary with sum_ready held low 5 cycles while in_valid=1 → counts stable, no pair accepted. sum_ready=1 → counts clear, in_ready=1 the next cycle.
- Reset after 3 accepted pairs → no summary. The next summary appears only after 4 further pairs.

Source files
------------

// File: rtl/window_compare_pkg.sv
// Shared verdict encodings and state type for the window_compare block.
package window_compare_pkg;

    localparam logic [2:0] CMP_GT = 3'b001;
    localparam logic [2:0] CMP_EQ = 3'b010;
    localparam logic [2:0] CMP_LT = 3'b100;

    typedef enum logic {
        ST_ACCUM,
        ST_REPORT
    } state_t;

endpackage

// File: rtl/window_compare_cmp_core.sv
// Combinational WIDTH-bit magnitude compare producing a one-hot verdict.
// Signed mode exists only when COMPARE_SIGNED_EN is defined.
module cmp_core
    import window_compare_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sgn,
    output logic [2:0]       verdict
);

    logic [WIDTH-1:0] a_k;
    logic [WIDTH-1:0] b_k;

`ifdef COMPARE_SIGNED_EN
    always_comb begin
        a_k = a;
        b_k = b;
        // Flipping the sign bit maps two's-complement order onto unsigned order.
        a_k[WIDTH-1] = a[WIDTH-1] ^ sgn;
        b_k[WIDTH-1] = b[WIDTH-1] ^ sgn;
    end
`else
    logic unused_sgn;
    assign unused_sgn = sgn;
    assign a_k = a;
    assign b_k = b;
`endif

    always_comb begin
        // NOTE: assign a default before any branch so no path infers a latch.
        verdict = CMP_EQ;
        if (a_k > b_k) begin
            verdict = CMP_GT;
        end else if (a_k < b_k) begin
            verdict = CMP_LT;
        end
    end

endmodule

// File: rtl/window_compare.sv
// Streaming comparator: per-pair one-hot verdict plus windowed tallies
// presented under a summary handshake. Optional signed mode: COMPARE_SIGNED_EN.
module window_compare
    import window_compare_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int WINDOW = 8,
    parameter int CW     = $clog2(WINDOW + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sgn,
    input  logic             flush,
    output logic             y_valid,
    output logic [2:0]       y,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic [CW-1:0]    cnt_gt,
    output logic [CW-1:0]    cnt_eq,
    output logic [CW-1:0]    cnt_lt
);

    state_t        state;
    logic [CW-1:0] pair_cnt;
    logic [2:0]    verdict;
    logic          accept;
    logic          last_pair;
    logic          close_win;

    cmp_core #(.WIDTH(WIDTH)) u_cmp (
        .a       (a),
        .b       (b),
        .sgn     (sgn),
        .verdict (verdict)
    );

    // Handshake flags decode the state register only, never in_valid.
    assign in_ready  = (state == ST_ACCUM);
    assign sum_valid = (state == ST_REPORT);

    assign accept    = in_valid && in_ready;
    assign last_pair = (pair_cnt == CW'(WINDOW - 1));
    assign close_win = (accept && last_pair) ||
                       (flush && ((pair_cnt != '0) || accept));

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_ACCUM;
            y        <= 3'b000;
            y_valid  <= 1'b0;
            pair_cnt <= '0;
            cnt_gt   <= '0;
            cnt_eq   <= '0;
            cnt_lt   <= '0;
        end else begin
            y_valid <= 1'b0;
            case (state)
                ST_ACCUM: begin
                    if (accept) begin
                        y        <= verdict;
                        y_valid  <= 1'b1;
                        pair_cnt <= pair_cnt + CW'(1);
                        case (verdict)
                            CMP_GT:  cnt_gt <= cnt_gt + CW'(1);
                            CMP_LT:  cnt_lt <= cnt_lt + CW'(1);
                            default: cnt_eq <= cnt_eq + CW'(1);
                        endcase
                    end
                    if (close_win) begin
                        state <= ST_REPORT;
                    end
                end
                ST_REPORT: begin
                    if (sum_ready) begin
                        state    <= ST_ACCUM;
                        pair_cnt <= '0;
                        cnt_gt   <= '0;
                        cnt_eq   <= '0;
                        cnt_lt   <= '0;
                    end
                end
                default: state <= ST_ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_window_compare.sv
// Directed self-checking bench for window_compare (WIDTH=4, WINDOW=4).
// Signed expectations follow COMPARE_SIGNED_EN.
module tb_window_compare;

    localparam int WIDTH  = 4;
    localparam int WINDOW = 4;
    localparam int CW     = $clog2(WINDOW + 1);

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sgn;
    logic             flush;
    logic             y_valid;
    logic [2:0]       y;
    logic             sum_valid;
    logic             sum_ready;
    logic [CW-1:0]    cnt_gt;
    logic [CW-1:0]    cnt_eq;
    logic [CW-1:0]    cnt_lt;

    int tests = 0;
    int fails = 0;

    window_compare #(.WIDTH(WIDTH), .WINDOW(WINDOW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sgn       (sgn),
        .flush     (flush),
        .y_valid   (y_valid),
        .y         (y),
        .sum_valid (sum_valid),
        .sum_ready (sum_ready),
        .cnt_gt    (cnt_gt),
        .cnt_eq    (cnt_eq),
        .cnt_lt    (cnt_lt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; outputs are then stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_counts(input string tag, input int gt, input int eq, input int lt);
        check({tag, ".gt"}, 8'(cnt_gt), 8'(gt));
        check({tag, ".eq"}, 8'(cnt_eq), 8'(eq));
        check({tag, ".lt"}, 8'(cnt_lt), 8'(lt));
    endtask

    task automatic drive(input logic v, input logic [3:0] av, input logic [3:0] bv);
        in_valid = v;
        a        = av;
        b        = bv;
    endtask

    task automatic release_summary();
        sum_ready = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        tick();
        sum_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sgn = 1'b0;
        flush = 1'b0; sum_ready = 1'b0;
        tick();
        tick();
        check("rst.y", 8'(y), 8'h00);
        check("rst.y_valid", 8'(y_valid), 8'h00);
        check("rst.sum_valid", 8'(sum_valid), 8'h00);
        check("rst.in_ready", 8'(in_ready), 8'h01);
        check_counts("rst", 0, 0, 0);
        rst = 1'b0;

        // Four back-to-back unsigned pairs close a window.
        drive(1'b1, 4'd5, 4'd3);  tick();
        check("bb1.y", 8'(y), 8'h01);
        check("bb1.y_valid", 8'(y_valid), 8'h01);
        check("bb1.sum_valid", 8'(sum_valid), 8'h00);
        drive(1'b1, 4'd3, 4'd3);  tick();
        check("bb2.y", 8'(y), 8'h02);
        drive(1'b1, 4'd2, 4'd9);  tick();
        check("bb3.y", 8'(y), 8'h04);
        check("bb3.in_ready", 8'(in_ready), 8'h01);
        drive(1'b1, 4'd15, 4'd0); tick();
        check("bb4.y", 8'(y), 8'h01);
        check("bb4.y_valid", 8'(y_valid), 8'h01);
        check("bb4.sum_valid", 8'(sum_valid), 8'h01);
        check("bb4.in_ready", 8'(in_ready), 8'h00);
        check_counts("bb4", 2, 1, 1);
        drive(1'b1, 4'd1, 4'd0);  tick();
        check("bbhold.y_valid", 8'(y_valid), 8'h00);
        check("bbhold.y", 8'(y), 8'h01);
        check("bbhold.in_ready", 8'(in_ready), 8'h00);
        check_counts("bbhold", 2, 1, 1);
        release_summary();
        check("bbclr.sum_valid", 8'(sum_valid), 8'h00);
        check("bbclr.in_ready", 8'(in_ready), 8'h01);
        check_counts("bbclr", 0, 0, 0);

        // Signed versus unsigned compare of 1111 against 0001.
        sgn = 1'b1; drive(1'b1, 4'b1111, 4'b0001); tick();
`ifdef COMPARE_SIGNED_EN
        check("sgn1.y", 8'(y), 8'h04);
`else
        check("sgn1.y", 8'(y), 8'h01);
`endif
        sgn = 1'b0; drive(1'b1, 4'b1111, 4'b0001); tick();
        check("sgn0.y", 8'(y), 8'h01);
        check("sgn0.y_valid", 8'(y_valid), 8'h01);
        drive(1'b0, 4'd0, 4'd0); flush = 1'b1; tick();
        flush = 1'b0;
        check("sgnflush.sum_valid", 8'(sum_valid), 8'h01);
`ifdef COMPARE_SIGNED_EN
        check_counts("sgnflush", 1, 0, 1);
`else
        check_counts("sgnflush", 2, 0, 0);
`endif
        release_summary();

        // Flush alone after two pairs.
        drive(1'b1, 4'd1, 4'd2); tick();
        check("fl1.y", 8'(y), 8'h04);
        drive(1'b1, 4'd7, 4'd7); tick();
        check("fl2.y", 8'(y), 8'h02);
        check("fl2.sum_valid", 8'(sum_valid), 8'h00);
        drive(1'b0, 4'd0, 4'd0); flush = 1'b1; tick();
        flush = 1'b0;
        check("fl3.sum_valid", 8'(sum_valid), 8'h01);
        check("fl3.y_valid", 8'(y_valid), 8'h00);
        check_counts("fl3", 0, 1, 1);
        release_summary();

        // Flush coinciding with the second pair's acceptance.
        drive(1'b1, 4'd1, 4'd2); tick();
        drive(1'b1, 4'd7, 4'd7); flush = 1'b1; tick();
        flush = 1'b0;
        check("flc.y", 8'(y), 8'h02);
        check("flc.y_valid", 8'(y_valid), 8'h01);
        check("flc.sum_valid", 8'(sum_valid), 8'h01);
        check_counts("flc", 0, 1, 1);
        release_summary();

        // Flush on an empty window does nothing.
        drive(1'b0, 4'd0, 4'd0); flush = 1'b1; tick();
        flush = 1'b0;
        check("fle.sum_valid", 8'(sum_valid), 8'h00);
        check("fle.in_ready", 8'(in_ready), 8'h01);
        tick();
        check("fle2.sum_valid", 8'(sum_valid), 8'h00);

        // Backpressure: full window of equal pairs, summary held 5 cycles.
        for (int i = 0; i < WINDOW; i++) begin
            drive(1'b1, 4'd6, 4'd6); tick();
        end
        check("bp.sum_valid", 8'(sum_valid), 8'h01);
        check_counts("bp", 0, 4, 0);
        drive(1'b1, 4'd9, 4'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bphold.sum_valid", 8'(sum_valid), 8'h01);
            check("bphold.y_valid", 8'(y_valid), 8'h00);
            check("bphold.in_ready", 8'(in_ready), 8'h00);
            check_counts("bphold", 0, 4, 0);
        end
        sum_ready = 1'b1; tick();
        sum_ready = 1'b0;
        check("bpclr.sum_valid", 8'(sum_valid), 8'h00);
        check("bpclr.in_ready", 8'(in_ready), 8'h01);
        check("bpclr.y_valid", 8'(y_valid), 8'h00);
        check_counts("bpclr", 0, 0, 0);
        tick();
        check("bpacc.y", 8'(y), 8'h01);
        check("bpacc.y_valid", 8'(y_valid), 8'h01);
        check("bpacc.gt", 8'(cnt_gt), 8'h01);

        // Two more pairs make three in the window, then reset mid-window.
        drive(1'b1, 4'd2, 4'd1); tick();
        drive(1'b1, 4'd3, 4'd1); tick();
        check("pre_rst.gt", 8'(cnt_gt), 8'h03);
        check("pre_rst.sum_valid", 8'(sum_valid), 8'h00);
        drive(1'b0, 4'd0, 4'd0);
        rst = 1'b1;
        #1;
        check("mrst.y", 8'(y), 8'h00);
        check("mrst.y_valid", 8'(y_valid), 8'h00);
        check("mrst.sum_valid", 8'(sum_valid), 8'h00);
        check("mrst.in_ready", 8'(in_ready), 8'h01);
        check_counts("mrst", 0, 0, 0);
        #1;
        rst = 1'b0;
        tick();

        // Summary only after four fresh pairs.
        for (int i = 0; i < WINDOW - 1; i++) begin
            drive(1'b1, 4'd4, 4'd5); tick();
            check("post_rst.sum_valid", 8'(sum_valid), 8'h00);
        end
        drive(1'b1, 4'd4, 4'd5); tick();
        check("post_rst4.sum_valid", 8'(sum_valid), 8'h01);
        check_counts("post_rst4", 0, 0, 4);
        release_summary();
        check("final.sum_valid", 8'(sum_valid), 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
